// File: rtl/xdma_read_meta_manager.sv
// xdma_read_meta_manager
//   Read-side meta tracker for xDMA. Queues read-request metadata (DMA id,
//   beat count) pushed by the read frontend, then serves the requests in
//   order. For each request it counts AXI R handshakes, pulses done with the
//   finished id on the final beat, and checks that RLAST lines up.
//
// Ports
//   clk_i, rst_ni      clock (rising edge), async active-low reset
//   meta_valid_i/ready meta push handshake; ready is !full
//   meta_id_i          DMA id of the pushed request
//   meta_len_i         beats expected for the pushed request
//   read_happening_i   R handshake this cycle
//   read_last_i        RLAST of the current beat
//   read_req_busy_o    a request is being counted
//   read_req_done_o    1-cycle pulse when the active request finishes
//   done_id_o          id of the finished request, held until the next done
//   cur_dma_id_o       id of the active request, 0 when not busy
//   beat_cnt_o         beats received for the active request
//   last_err_o         1-cycle pulse on RLAST mismatch or stray beat
//   outstanding_o      meta FIFO occupancy
module xdma_read_meta_manager #(
    parameter int unsigned IdWidth   = 8,
    parameter int unsigned LenWidth  = 16,
    parameter int unsigned MetaDepth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         meta_valid_i,
    output logic                         meta_ready_o,
    input  logic [IdWidth-1:0]           meta_id_i,
    input  logic [LenWidth-1:0]          meta_len_i,
    input  logic                         read_happening_i,
    input  logic                         read_last_i,
    output logic                         read_req_busy_o,
    output logic                         read_req_done_o,
    output logic [IdWidth-1:0]           done_id_o,
    output logic [IdWidth-1:0]           cur_dma_id_o,
    output logic [LenWidth-1:0]          beat_cnt_o,
    output logic                         last_err_o,
    output logic [$clog2(MetaDepth):0]   outstanding_o
);

    localparam int unsigned PtrWidth = $clog2(MetaDepth);
    localparam int unsigned CntWidth = PtrWidth + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [IdWidth-1:0]  fifo_id  [MetaDepth];
    logic [LenWidth-1:0] fifo_len [MetaDepth];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                full, empty, push, pop;

    logic [IdWidth-1:0]  meta_id_q, done_id_q;
    logic [LenWidth-1:0] meta_len_q;
    logic [LenWidth-1:0] cnt_q, cnt_d;
    logic                final_beat, done, err;

    // FIFO status; a same-cycle pop does not relieve a full FIFO
    assign full  = (count_q == CntWidth'(MetaDepth));
    assign empty = (count_q == '0);
    assign push  = meta_valid_i && !full;

    // Meta storage (no reset needed, qualified by pointers/count)
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_id[wr_ptr_q]  <= meta_id_i;
            fifo_len[wr_ptr_q] <= meta_len_i;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            count_q <= count_q + CntWidth'(push) - CntWidth'(pop);
        end
    end

    // Final beat: counter compared against len-1 in LenWidth arithmetic
    assign final_beat = (state_q == BUSY) && read_happening_i &&
                        (cnt_q == meta_len_q - LenWidth'(1));

    // Next-state, beat counter, done and RLAST checking
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                err = read_happening_i;
                if (!empty) begin
                    pop     = 1'b1;
                    cnt_d   = '0;
                    state_d = (fifo_len[rd_ptr_q] != '0) ? BUSY : FINISH;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + LenWidth'(read_happening_i);
                if (read_happening_i) begin
                    err = final_beat ? !read_last_i : read_last_i;
                end
                if (final_beat) begin
                    done    = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                err     = read_happening_i;
                cnt_d   = '0;
                state_d = IDLE;
                // zero-length requests report completion here
                done    = (meta_len_q == '0);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and active-request registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            meta_id_q  <= '0;
            meta_len_q <= '0;
            done_id_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pop) begin
                meta_id_q  <= fifo_id[rd_ptr_q];
                meta_len_q <= fifo_len[rd_ptr_q];
            end
            if (done) begin
                done_id_q <= meta_id_q;
            end
        end
    end

    assign meta_ready_o    = !full;
    assign read_req_busy_o = (state_q == BUSY);
    assign read_req_done_o = done;
    assign done_id_o       = done ? meta_id_q : done_id_q;
    assign cur_dma_id_o    = (state_q == BUSY) ? meta_id_q : '0;
    assign beat_cnt_o      = cnt_q;
    assign last_err_o      = err;
    assign outstanding_o   = count_q;

endmodule

// File: tb/tb_xdma_read_meta_manager.sv
// Testbench for xdma_read_meta_manager: directed scenarios followed by a
// randomized phase checked against a transaction-level scoreboard.
module tb_xdma_read_meta_manager;

    logic        clk;
    logic        rst_n;
    logic        meta_valid;
    logic        meta_ready;
    logic [7:0]  meta_id;
    logic [15:0] meta_len;
    logic        read_happening;
    logic        read_last;
    logic        busy;
    logic        done;
    logic [7:0]  done_id;
    logic [7:0]  cur_id;
    logic [15:0] beat_cnt;
    logic        last_err;
    logic [2:0]  outstanding;

    int checks;
    int failures;

    typedef struct {
        logic [7:0]  id;
        logic [15:0] len;
    } meta_t;

    meta_t exp_q[$];
    int    beats_seen;

    xdma_read_meta_manager dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .meta_valid_i     (meta_valid),
        .meta_ready_o     (meta_ready),
        .meta_id_i        (meta_id),
        .meta_len_i       (meta_len),
        .read_happening_i (read_happening),
        .read_last_i      (read_last),
        .read_req_busy_o  (busy),
        .read_req_done_o  (done),
        .done_id_o        (done_id),
        .cur_dma_id_o     (cur_id),
        .beat_cnt_o       (beat_cnt),
        .last_err_o       (last_err),
        .outstanding_o    (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs applied just after the rising edge, outputs sampled 2ns later
    task automatic drive(input logic mv, input logic [7:0] id, input logic [15:0] len,
                         input logic rh, input logic rl);
        @(posedge clk);
        #1;
        meta_valid     = mv;
        meta_id        = id;
        meta_len       = len;
        read_happening = rh;
        read_last      = rl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    endtask

    // Randomized cycle checked against the in-order request scoreboard
    task automatic sb_cycle(input bit allow_push, input bit all_beats);
        logic mv, rh, rl, fin, busy_now;
        logic [7:0] id;
        logic [15:0] len;
        @(posedge clk);
        #1;
        busy_now = busy;
        mv  = allow_push && ($urandom_range(0, 99) < 30);
        id  = 8'($urandom);
        len = 16'($urandom_range(0, 5));
        fin = 1'b0;
        if (busy_now) begin
            rh = all_beats ? 1'b1 : ($urandom_range(0, 99) < 70);
            if (exp_q.size() > 0)
                fin = rh && (beats_seen == int'(exp_q[0].len) - 1);
        end else begin
            rh = allow_push && ($urandom_range(0, 99) < 5);
        end
        rl = rh ? (($urandom_range(0, 9) == 0) ? !fin : fin) : 1'($urandom);
        meta_valid     = mv;
        meta_id        = id;
        meta_len       = len;
        read_happening = rh;
        read_last      = rl;
        #1;
        if (busy_now) begin
            chk("sb_busy_has_meta", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                chk("sb_cur_id", 32'(cur_id), 32'(exp_q[0].id));
                chk("sb_beat_cnt", 32'(beat_cnt), 32'(beats_seen));
                chk("sb_done", 32'(done), 32'(fin));
                chk("sb_err", 32'(last_err), 32'(rh && (rl != fin)));
                if (fin) chk("sb_done_id", 32'(done_id), 32'(exp_q[0].id));
                if (rh) begin
                    if (fin) begin
                        void'(exp_q.pop_front());
                        beats_seen = 0;
                    end else begin
                        beats_seen++;
                    end
                end
            end
        end else begin
            chk("sb_stray_err", 32'(last_err), 32'(rh));
            chk("sb_cur_id_idle", 32'(cur_id), 32'd0);
            if (done) begin
                chk("sb_done_has_meta", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("sb_zero_len_done", 32'(exp_q[0].len), 32'd0);
                    chk("sb_zero_len_id", 32'(done_id), 32'(exp_q[0].id));
                    void'(exp_q.pop_front());
                end
            end
        end
        if (mv && meta_ready) exp_q.push_back('{id: id, len: len});
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || outstanding != 0 || busy) && n < 400) begin
            sb_cycle(1'b0, 1'b1);
            n++;
        end
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_outstanding"}, 32'(outstanding), 32'd0);
        idle();
        idle();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        beats_seen = 0;
        rst_n = 1'b0;
        meta_valid = 1'b0;
        meta_id = '0;
        meta_len = '0;
        read_happening = 1'b0;
        read_last = 1'b0;

        // Reset state
        #3;
        chk("rst_ready", 32'(meta_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_cur_id", 32'(cur_id), 32'd0);
        chk("rst_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_err", 32'(last_err), 32'd0);
        chk("rst_out", 32'(outstanding), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // id=5 len=4, RLAST on the 4th beat
        drive(1'b1, 8'd5, 16'd4, 1'b0, 1'b0);
        chk("t1_ready", 32'(meta_ready), 32'd1);
        chk("t1_out_push", 32'(outstanding), 32'd0);
        idle();
        chk("t1_out_pop", 32'(outstanding), 32'd1);
        chk("t1_busy_pre", 32'(busy), 32'd0);
        for (int b = 0; b < 4; b++) begin
            drive(1'b0, 8'd0, 16'd0, 1'b1, 1'(b == 3));
            chk("t1_busy", 32'(busy), 32'd1);
            chk("t1_cur_id", 32'(cur_id), 32'd5);
            chk("t1_cnt", 32'(beat_cnt), 32'(b));
            chk("t1_done", 32'(done), 32'(b == 3));
            chk("t1_err", 32'(last_err), 32'd0);
            if (b == 3) chk("t1_done_id", 32'(done_id), 32'd5);
        end
        idle();
        chk("t1_fin_busy", 32'(busy), 32'd0);
        chk("t1_fin_done", 32'(done), 32'd0);
        chk("t1_fin_done_id", 32'(done_id), 32'd5);
        chk("t1_fin_cur_id", 32'(cur_id), 32'd0);
        chk("t1_fin_cnt", 32'(beat_cnt), 32'd4);
        idle();
        chk("t1_idle_cnt", 32'(beat_cnt), 32'd0);

        // id=1 len=1 then id=2 len=3
        drive(1'b1, 8'd1, 16'd1, 1'b0, 1'b0);
        chk("t2_out_a", 32'(outstanding), 32'd0);
        drive(1'b1, 8'd2, 16'd3, 1'b0, 1'b0);
        chk("t2_out_b", 32'(outstanding), 32'd1);
        drive(1'b0, 8'd0, 16'd0, 1'b1, 1'b1);
        chk("t2_cur_id1", 32'(cur_id), 32'd1);
        chk("t2_done1", 32'(done), 32'd1);
        chk("t2_done_id1", 32'(done_id), 32'd1);
        chk("t2_out_c", 32'(outstanding), 32'd1);
        idle();
        chk("t2_fin_busy", 32'(busy), 32'd0);
        idle();
        chk("t2_idle_out", 32'(outstanding), 32'd1);
        for (int b = 0; b < 3; b++) begin
            drive(1'b0, 8'd0, 16'd0, 1'b1, 1'(b == 2));
            chk("t2_cur_id2", 32'(cur_id), 32'd2);
            chk("t2_out_d", 32'(outstanding), 32'd0);
            chk("t2_done2", 32'(done), 32'(b == 2));
            if (b == 2) chk("t2_done_id2", 32'(done_id), 32'd2);
        end
        idle();
        idle();

        // Fill the FIFO behind an active request; full with pop still not ready
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'(8'h10 + k), 16'd2, 1'b0, 1'b0);
            chk("t3_ready_fill", 32'(meta_ready), 32'd1);
        end
        drive(1'b1, 8'h15, 16'd1, 1'b1, 1'b0);
        chk("t3_ready_full", 32'(meta_ready), 32'd0);
        chk("t3_out_full", 32'(outstanding), 32'd4);
        chk("t3_cnt", 32'(beat_cnt), 32'd0);
        drive(1'b1, 8'h15, 16'd1, 1'b1, 1'b1);
        chk("t3_ready_x2", 32'(meta_ready), 32'd0);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_done_id", 32'(done_id), 32'h10);
        drive(1'b1, 8'h15, 16'd1, 1'b0, 1'b0);
        chk("t3_ready_fin", 32'(meta_ready), 32'd0);
        drive(1'b1, 8'h15, 16'd1, 1'b0, 1'b0);
        chk("t3_ready_pop", 32'(meta_ready), 32'd0);
        chk("t3_busy_pop", 32'(busy), 32'd0);
        drive(1'b1, 8'h15, 16'd1, 1'b0, 1'b0);
        chk("t3_ready_free", 32'(meta_ready), 32'd1);
        chk("t3_cur_id", 32'(cur_id), 32'h11);
        idle();
        chk("t3_ready_refull", 32'(meta_ready), 32'd0);
        chk("t3_out_refull", 32'(outstanding), 32'd4);
        for (int k = 1; k < 5; k++) exp_q.push_back('{id: 8'(8'h10 + k), len: 16'd2});
        exp_q.push_back('{id: 8'h15, len: 16'd1});
        beats_seen = 0;
        drain("t3_drain");

        // id=7 len=3 with early RLAST on beat 2
        drive(1'b1, 8'd7, 16'd3, 1'b0, 1'b0);
        idle();
        for (int b = 0; b < 3; b++) begin
            drive(1'b0, 8'd0, 16'd0, 1'b1, 1'(b >= 1));
            chk("t4_err", 32'(last_err), 32'(b == 1));
            chk("t4_done", 32'(done), 32'(b == 2));
            chk("t4_cnt", 32'(beat_cnt), 32'(b));
            if (b == 2) chk("t4_done_id", 32'(done_id), 32'd7);
        end
        idle();
        idle();

        // Zero-length request, then a stray beat in IDLE
        drive(1'b1, 8'd9, 16'd0, 1'b0, 1'b0);
        chk("t5_done_a", 32'(done), 32'd0);
        idle();
        chk("t5_done_b", 32'(done), 32'd0);
        chk("t5_busy_b", 32'(busy), 32'd0);
        idle();
        chk("t5_done_c", 32'(done), 32'd1);
        chk("t5_done_id", 32'(done_id), 32'd9);
        chk("t5_busy_c", 32'(busy), 32'd0);
        chk("t5_cnt_c", 32'(beat_cnt), 32'd0);
        drive(1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
        chk("t5_stray_err", 32'(last_err), 32'd1);
        chk("t5_stray_done", 32'(done), 32'd0);
        chk("t5_hold_id", 32'(done_id), 32'd9);
        idle();
        chk("t5_err_clear", 32'(last_err), 32'd0);
        chk("t5_stray_cnt", 32'(beat_cnt), 32'd0);

        // Reset mid-transfer discards active and queued meta
        drive(1'b1, 8'h20, 16'd8, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 16'd3, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
        drive(1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
        chk("t6_cnt_pre", 32'(beat_cnt), 32'd1);
        @(posedge clk);
        #1;
        read_happening = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_ready", 32'(meta_ready), 32'd1);
        chk("t6_out", 32'(outstanding), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done_id", 32'(done_id), 32'd0);
        chk("t6_cur_id", 32'(cur_id), 32'd0);
        chk("t6_cnt", 32'(beat_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 8'h21, 16'd2, 1'b0, 1'b0);
        chk("t6_out_new", 32'(outstanding), 32'd0);
        idle();
        chk("t6_out_one", 32'(outstanding), 32'd1);
        for (int b = 0; b < 2; b++) begin
            drive(1'b0, 8'd0, 16'd0, 1'b1, 1'(b == 1));
            chk("t6_new_cnt", 32'(beat_cnt), 32'(b));
            chk("t6_new_cur", 32'(cur_id), 32'h21);
            chk("t6_new_done", 32'(done), 32'(b == 1));
        end
        idle();
        idle();
        chk("t6_out_end", 32'(outstanding), 32'd0);
        chk("t6_busy_end", 32'(busy), 32'd0);

        // Randomized traffic against the scoreboard
        exp_q.delete();
        beats_seen = 0;
        for (int i = 0; i < 600; i++) sb_cycle(1'b1, 1'b0);
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
